// File: rtl/cadder_tree_pkg.sv
// cadder_pkg: width, latency and saturation helpers shared by the complex adder tree
package cadder_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int p = 1; p < n; p = p * 2) r++;
    return r;
  endfunction
  function automatic int swidth(input int dw, input int n);
    return dw + clog2(n);
  endfunction
  function automatic int latency(input int n);
    return clog2(n) + 2;
  endfunction
  function automatic int sat_max(input int ow);
    return (1 << (ow - 1)) - 1;
  endfunction
  function automatic int sat_min(input int ow);
    return -(1 << (ow - 1));
  endfunction
  localparam int SWIDTH = swidth(16, 8);
  localparam int L = latency(8);
endpackage

// File: rtl/cadder_tree_if.sv
// cadder_tree_if: streaming complex-lane input and rounded/saturated output bundle
interface cadder_tree_if #(
  parameter int DWIDTH = 16,
  parameter int NUM_IN = 8,
  parameter int OWIDTH = DWIDTH + 3
);
  logic                       din_valid;
  logic [NUM_IN*2*DWIDTH-1:0] din;
  logic [NUM_IN-1:0]          lane_mask;
  logic [3:0]                 shift;
  logic                       ovf_clr;
  logic                       dout_valid;
  logic [2*OWIDTH-1:0]        dout;
  logic                       dout_sat;
  logic                       ovf_flag;
  modport master (
    output din_valid, din, lane_mask, shift, ovf_clr,
    input  dout_valid, dout, dout_sat, ovf_flag
  );
  modport slave (
    input  din_valid, din, lane_mask, shift, ovf_clr,
    output dout_valid, dout, dout_sat, ovf_flag
  );
endinterface

// File: rtl/cadder_tree_adder_tree.sv
// adder_tree: masked real lanes -> registered binary tree -> round half-up, saturate
module adder_tree
  import cadder_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int NUM_IN    = 8,
  parameter int OWIDTH    = DWIDTH + 3,
  parameter bit HAS_VALID = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_in,
  input  logic                     en_in,
  input  logic [NUM_IN*DWIDTH-1:0] lanes,
  input  logic [NUM_IN-1:0]        mask,
  input  logic [3:0]               shift,
  output logic                     en_out,
  output logic                     vld_out,
  output logic [OWIDTH-1:0]        dout,
  output logic                     sat
);
  localparam int LG = clog2(NUM_IN);
  localparam int SW = swidth(DWIDTH, NUM_IN);
  localparam int NN = 2 * NUM_IN - 1;
  localparam logic signed [SW:0] SMAX = (SW+1)'(sat_max(OWIDTH));
  localparam logic signed [SW:0] SMIN = (SW+1)'(sat_min(OWIDTH));
  // leaves occupy node[0..NUM_IN-1]; node n >= NUM_IN sums node[2(n-NUM_IN)] and its sibling
  logic signed [SW-1:0] node [NN];
  logic [3:0]           sh [LG+1];
  logic [3:0]           sh_c;
  logic signed [SW:0]   rnd, sum_r;
  logic                 en;
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_IN; k++)
      node[k] <= rst || !mask[k] ? '0 : SW'($signed(lanes[k*DWIDTH +: DWIDTH]));
    for (int n = NUM_IN; n < NN; n++)
      node[n] <= rst ? '0 : node[2*(n-NUM_IN)] + node[2*(n-NUM_IN)+1];
    sh[0] <= rst ? '0 : shift;
    for (int l = 1; l <= LG; l++)
      sh[l] <= rst ? '0 : sh[l-1];
  end
  if (HAS_VALID) begin : g_vld
    logic [LG:0] vld;
    wire unused_en = en_in;
    always_ff @(posedge clk) begin
      vld     <= rst ? '0 : {vld[LG-1:0], vld_in};
      vld_out <= !rst && vld[LG];
    end
    assign en = vld[LG];
  end else begin : g_nvld
    wire unused_vld = vld_in;
    assign en      = en_in;
    assign vld_out = 1'b0;
  end
  assign en_out = en;
  // one extra bit keeps the rounding increment from wrapping
  always_comb begin
    sh_c  = 32'(sh[LG]) >= SW ? 4'(SW - 1) : sh[LG];
    rnd   = sh_c == 4'd0 ? '0 : (SW+1)'(1) << (sh_c - 4'd1);
    sum_r = ($signed({node[NN-1][SW-1], node[NN-1]}) + rnd) >>> sh_c;
  end
  always_ff @(posedge clk)
    if (rst) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if (en) begin
      dout <= sum_r > SMAX ? SMAX[OWIDTH-1:0] : sum_r < SMIN ? SMIN[OWIDTH-1:0] : sum_r[OWIDTH-1:0];
      sat  <= sum_r > SMAX || sum_r < SMIN;
    end
endmodule

// File: rtl/cadder_tree.sv
// cadder_tree: complex masked lane sum with rounding shift, saturation and sticky overflow
module cadder_tree
  import cadder_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int NUM_IN = 8,
  parameter int OWIDTH = DWIDTH + 3
) (
  input logic         clk,
  input logic         rst,
  cadder_tree_if.slave bus
);
  logic [NUM_IN*DWIDTH-1:0] lanes_i, lanes_q;
  logic [OWIDTH-1:0]        dout_i, dout_q;
  logic                     en, sat_i, sat_q;
  logic [1:0]               unused_q;
  for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
    assign lanes_i[k*DWIDTH +: DWIDTH] = bus.din[(2*k+1)*DWIDTH +: DWIDTH];
    assign lanes_q[k*DWIDTH +: DWIDTH] = bus.din[2*k*DWIDTH +: DWIDTH];
  end
  adder_tree #(.DWIDTH(DWIDTH), .NUM_IN(NUM_IN), .OWIDTH(OWIDTH), .HAS_VALID(1'b1)) u_i (
    .clk(clk), .rst(rst), .vld_in(bus.din_valid), .en_in(1'b0), .lanes(lanes_i),
    .mask(bus.lane_mask), .shift(bus.shift), .en_out(en), .vld_out(bus.dout_valid),
    .dout(dout_i), .sat(sat_i)
  );
  // Q follows the I valid pipeline through en
  adder_tree #(.DWIDTH(DWIDTH), .NUM_IN(NUM_IN), .OWIDTH(OWIDTH), .HAS_VALID(1'b0)) u_q (
    .clk(clk), .rst(rst), .vld_in(1'b0), .en_in(en), .lanes(lanes_q),
    .mask(bus.lane_mask), .shift(bus.shift), .en_out(unused_q[0]), .vld_out(unused_q[1]),
    .dout(dout_q), .sat(sat_q)
  );
  assign bus.dout     = {dout_i, dout_q};
  assign bus.dout_sat = sat_i | sat_q;
  always_ff @(posedge clk)
    bus.ovf_flag <= !rst && ((bus.dout_valid && bus.dout_sat) || (bus.ovf_flag && !bus.ovf_clr));
endmodule

// File: tb/tb_cadder_tree.sv
// tb_cadder_tree: scoreboard bench driving OWIDTH=19 and OWIDTH=16 instances in lockstep
module tb_cadder_tree;
  localparam int DW  = 16;
  localparam int N   = 8;
  localparam int SW  = DW + $clog2(N);
  localparam int LAT = $clog2(N) + 2;
  localparam int DBITS = N * 2 * DW;
  typedef struct {
    int due;
    int i19, q19, i16, q16;
    bit s19, s16;
  } exp_t;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             vin = 1'b0;
  logic [DBITS-1:0] din = '0;
  logic [N-1:0]     mask = '0;
  logic [3:0]       shift = '0;
  logic             clr = 1'b0;
  exp_t q[$];
  int cyc = 0, n_tests = 0, n_fail = 0;
  int li19 = 0, lq19 = 0, li16 = 0, lq16 = 0;
  bit ls19 = 0, ls16 = 0, ev = 0, ovf19 = 0, ovf16 = 0;
  always #5 clk = ~clk;
  cadder_tree_if #(.DWIDTH(DW), .NUM_IN(N), .OWIDTH(19)) b19 ();
  cadder_tree_if #(.DWIDTH(DW), .NUM_IN(N), .OWIDTH(16)) b16 ();
  cadder_tree #(.DWIDTH(DW), .NUM_IN(N), .OWIDTH(19)) dut19 (.clk(clk), .rst(rst), .bus(b19));
  cadder_tree #(.DWIDTH(DW), .NUM_IN(N), .OWIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  assign b19.din_valid = vin;
  assign b19.din       = din;
  assign b19.lane_mask = mask;
  assign b19.shift     = shift;
  assign b19.ovf_clr   = clr;
  assign b16.din_valid = vin;
  assign b16.din       = din;
  assign b16.lane_mask = mask;
  assign b16.shift     = shift;
  assign b16.ovf_clr   = clr;
  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic void model(input logic [DBITS-1:0] d, input logic [N-1:0] m,
                                input logic [3:0] s, input int ow,
                                output int oi, output int oq, output bit sat);
    longint si, sq, mx, mn;
    int sc;
    si = 0;
    sq = 0;
    for (int k = 0; k < N; k++)
      if (m[k]) begin
        si += longint'($signed(d[(2*k+1)*DW +: DW]));
        sq += longint'($signed(d[2*k*DW +: DW]));
      end
    sc = int'(s) >= SW ? SW - 1 : int'(s);
    if (sc > 0) begin
      si = (si + (longint'(1) << (sc - 1))) >>> sc;
      sq = (sq + (longint'(1) << (sc - 1))) >>> sc;
    end
    mx  = (longint'(1) << (ow - 1)) - 1;
    mn  = -(longint'(1) << (ow - 1));
    sat = si > mx || si < mn || sq > mx || sq < mn;
    oi  = int'(si > mx ? mx : si < mn ? mn : si);
    oq  = int'(sq > mx ? mx : sq < mn ? mn : sq);
  endfunction
  function automatic logic [DBITS-1:0] rnd_din();
    logic [DBITS-1:0] d;
    for (int k = 0; k < DBITS / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction
  function automatic logic [DBITS-1:0] fill(input logic [DW-1:0] i, input logic [DW-1:0] qv);
    logic [DBITS-1:0] d;
    for (int k = 0; k < N; k++) d[k*2*DW +: 2*DW] = {i, qv};
    return d;
  endfunction
  function automatic longint oi19(); return longint'($signed(b19.dout[37:19])); endfunction
  function automatic longint oq19(); return longint'($signed(b19.dout[18:0])); endfunction
  function automatic longint oi16(); return longint'($signed(b16.dout[31:16])); endfunction
  function automatic longint oq16(); return longint'($signed(b16.dout[15:0])); endfunction
  // one clock: record stimulus, advance, then compare outputs at the falling edge
  task automatic tick();
    exp_t e;
    bit n19, n16;
    n19 = !rst && ((ev && ls19) || (ovf19 && !clr));
    n16 = !rst && ((ev && ls16) || (ovf16 && !clr));
    if (rst) q.delete();
    else if (vin) begin
      e.due = cyc + LAT;
      model(din, mask, shift, 19, e.i19, e.q19, e.s19);
      model(din, mask, shift, 16, e.i16, e.q16, e.s16);
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    ovf19 = n19;
    ovf16 = n16;
    ev = 1'b0;
    if (rst) begin
      {li19, lq19, li16, lq16} = '0;
      {ls19, ls16} = '0;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev = 1'b1;
      li19 = e.i19; lq19 = e.q19; ls19 = e.s19;
      li16 = e.i16; lq16 = e.q16; ls16 = e.s16;
    end
    @(negedge clk);
    check("valid19", longint'(b19.dout_valid), longint'(ev));
    check("valid16", longint'(b16.dout_valid), longint'(ev));
    check("i19", oi19(), longint'(li19));
    check("q19", oq19(), longint'(lq19));
    check("sat19", longint'(b19.dout_sat), longint'(ls19));
    check("ovf19", longint'(b19.ovf_flag), longint'(ovf19));
    check("i16", oi16(), longint'(li16));
    check("q16", oq16(), longint'(lq16));
    check("sat16", longint'(b16.dout_sat), longint'(ls16));
    check("ovf16", longint'(b16.ovf_flag), longint'(ovf16));
  endtask
  task automatic send(input bit v, input logic [DBITS-1:0] d, input logic [N-1:0] m, input logic [3:0] s);
    vin = v;
    din = d;
    mask = m;
    shift = s;
    tick();
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(1'b0, rnd_din(), 8'($urandom), 4'($urandom));
  endtask
  initial begin
    logic [DBITS-1:0] d;
    rst = 1'b1;
    send(1'b1, rnd_din(), 8'hff, 4'd0);
    idle(2);
    rst = 1'b0;
    idle(2);
    send(1'b1, fill(16'h7fff, 16'h8000), 8'hff, 4'd0);
    idle(LAT + 1);
    check("sat_i16", oi16(), 32767);
    check("sat_q16", oq16(), -32768);
    check("sat_flag16", longint'(b16.dout_sat), 1);
    check("sat_ovf16", longint'(b16.ovf_flag), 1);
    send(1'b1, fill(16'h7fff, 16'h8000), 8'hff, 4'd3);
    idle(LAT + 1);
    check("shr3_i16", oi16(), 32767);
    check("shr3_q16", oq16(), -32768);
    check("shr3_sat16", longint'(b16.dout_sat), 0);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    d = rnd_din();
    for (int k = 0; k < N; k++) d[(2*k+1)*DW +: DW] = k == 0 ? 16'd100 : k == N-1 ? 16'(-30) : 16'd1000;
    send(1'b1, d, 8'h81, 4'd0);
    for (int k = 1; k < LAT; k++) begin
      check("m81_early", longint'(b19.dout_valid), 0);
      idle(1);
    end
    check("m81_valid", longint'(b19.dout_valid), 1);
    check("m81_i19", oi19(), 70);
    send(1'b1, rnd_din(), 8'hff, 4'd1);
    send(1'b1, rnd_din(), 8'h5a, 4'd2);
    send(1'b0, rnd_din(), 8'hff, 4'd0);
    send(1'b1, rnd_din(), 8'hc3, 4'd0);
    idle(LAT + 1);
    for (int t = 0; t < 80; t++) begin
      clr = $urandom_range(7) == 0;
      send($urandom_range(3) != 0,
           $urandom_range(3) == 0 ? fill(16'h7fff, 16'h8000) : rnd_din(),
           $urandom_range(4) == 0 ? 8'hff : 8'($urandom),
           $urandom_range(2) == 0 ? 4'd0 : 4'($urandom_range(15)));
    end
    clr = 1'b0;
    idle(LAT + 1);
    send(1'b1, rnd_din(), 8'h00, 4'd0);
    idle(LAT + 1);
    check("mask0_i19", oi19(), 0);
    check("mask0_q19", oq19(), 0);
    check("mask0_sat19", longint'(b19.dout_sat), 0);
    for (int k = 0; k < 3; k++) send(1'b1, rnd_din(), 8'hff, 4'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(LAT + 2);
    check("rst_i19", oi19(), 0);
    check("rst_q19", oq19(), 0);
    check("rst_sat19", longint'(b19.dout_sat), 0);
    check("rst_ovf16", longint'(b16.ovf_flag), 0);
    send(1'b1, fill(16'h7fff, 16'h8000), 8'hff, 4'd0);
    idle(LAT - 1);
    check("clr_valid16", longint'(b16.dout_valid), 1);
    check("clr_sat16", longint'(b16.dout_sat), 1);
    clr = 1'b1;
    idle(1);
    check("clr_setwins16", longint'(b16.ovf_flag), 1);
    idle(1);
    check("clr_cleared16", longint'(b16.ovf_flag), 0);
    clr = 1'b0;
    idle(LAT + 1);
    check("sb_empty", longint'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cadder_tree.md
CADDER_TREE -- requirements
Module: cadder_tree

Interface
REQ-001 Parameter DWIDTH, default 16: width of each I and each Q input component, signed two's complement.
REQ-002 Parameter NUM_IN, default 8: number of complex input lanes; legal values are powers of two from 2 to 32.
REQ-003 Parameter OWIDTH, default DWIDTH+3: width of each output component, signed; legal range 2..DWIDTH+log2(NUM_IN).
REQ-004 clk  in  1  single clock; every register is on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 din_valid  in  1  qualifies din, lane_mask and shift in the same cycle.
REQ-007 din  in  NUM_IN*2*DWIDTH  packed lanes; lane k occupies bits [(k+1)*2*DWIDTH-1 : k*2*DWIDTH] as {i,q}.
REQ-008 lane_mask  in  NUM_IN  bit k=1 includes lane k in the sum; bit k=0 forces lane k to contribute zero.
REQ-009 shift  in  4  right-shift amount applied to the full-precision sum.
REQ-010 ovf_clr  in  1  clears the sticky overflow flag.
REQ-011 dout_valid  out  1  qualifies dout and dout_sat.
REQ-012 dout  out  2*OWIDTH  result as {dout_i, dout_q}.
REQ-013 dout_sat  out  1  the current dout had I or Q saturated.
REQ-014 ovf_flag  out  1  sticky flag; set by any saturated valid output.

Function
REQ-015 The pipeline SHALL have no backpressure and SHALL advance every cycle; din_valid may be asserted on any cycle, including back-to-back.
REQ-016 Stage 0 SHALL register the masked lanes, shift and din_valid.
REQ-017 The next log2(NUM_IN) stages SHALL form a registered binary adder tree, one level per stage, with pairs (2j, 2j+1) added at each level.
REQ-018 Full sum width SWIDTH = DWIDTH+log2(NUM_IN); tree levels SHALL sign-extend so that no intermediate overflow is possible.
REQ-019 The final stage SHALL round half-up: if shift>0, add 2^(shift-1), then arithmetic-shift right by shift.
REQ-020 A shift value of SWIDTH or more SHALL be clamped to SWIDTH-1.
REQ-021 After rounding, the final stage SHALL saturate each component to the OWIDTH signed range [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
REQ-022 The rounding add SHALL be performed at SWIDTH+1 bits so that it cannot wrap.
REQ-023 Latency L = log2(NUM_IN)+2 cycles from a din_valid sample to dout_valid; for the defaults L = 5.
REQ-024 dout_valid SHALL be din_valid delayed by exactly L cycles.
REQ-025 dout and dout_sat SHALL update only when dout_valid is asserted and SHALL hold their last values otherwise.
REQ-026 dout_sat=1 SHALL be asserted iff I or Q was clipped on that output.
REQ-027 ovf_flag SHALL be set on a cycle with dout_valid=1 and dout_sat=1.
REQ-028 ovf_flag SHALL be cleared by ovf_clr=1; when set and clear occur in the same cycle, set wins.
REQ-029 When lane_mask is all zero, the output SHALL be zero with dout_sat=0.

Reset
REQ-030 While rst=1, all pipeline data registers, all valid bits, dout, dout_sat and ovf_flag SHALL be 0 on the next edge.
REQ-031 A rst asserted mid-operation SHALL discard all in-flight samples; no dout_valid SHALL occur until L cycles after the first post-reset din_valid.

Structure
REQ-032 Package cadder_pkg SHALL hold the clog2 function, the SWIDTH and L derivations, and the saturation-limit constants.
REQ-033 Sub-module adder_tree (real-only tree plus round/saturate, parametrised on DWIDTH, NUM_IN and OWIDTH) SHALL be instantiated twice, for I and Q.
REQ-034 The valid pipeline SHALL live in the I instance only, and the two sat flags SHALL be ORed at top level.

Verification (defaults DWIDTH=16, NUM_IN=8, OWIDTH=19 unless stated)
REQ-035 OWIDTH=16, all lanes i=0x7FFF and q=0x8000, mask=0xFF, shift=0 -> dout_i=32767, dout_q=-32768, dout_sat=1, ovf_flag=1.
REQ-036 Same stimulus with shift=3 -> dout_i=32767, dout_q=-32768, dout_sat=0.
REQ-037 mask=0x81, lane0 i=100, lane7 i=-30, all other lanes i=1000 -> dout_i=70 exactly 5 cycles after din_valid.
REQ-038 din_valid pattern 1,1,0,1 with distinct data -> dout_valid pattern 1,1,0,1 starting at cycle 5; dout holds its value during the gap.
REQ-039 Pulse rst one cycle, two cycles after a 3-sample burst -> dout_valid never asserts and all outputs read 0.
REQ-040 ovf_clr=1 in the same cycle as a saturated output -> ovf_flag stays 1; ovf_clr on the next cycle -> ovf_flag=0.
